// File: rtl/datapath_ctrl_pkg.sv
// Shared types and codes for the scheduled datapath controller: FSM states,
// operand-select codes and ALU/MUL op codes.
package datapath_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M2   = 3'd1,
    A4   = 3'd2,
    M6   = 3'd3,
    A8   = 3'd4,
    M10  = 3'd5,
    A12  = 3'd6,
    RES  = 3'd7
  } state_e;

  localparam int SEL_WIDTH = 4;

  localparam logic [SEL_WIDTH-1:0] SEL_I1    = 4'd0;
  localparam logic [SEL_WIDTH-1:0] SEL_I2    = 4'd1;
  localparam logic [SEL_WIDTH-1:0] SEL_I3    = 4'd2;
  localparam logic [SEL_WIDTH-1:0] SEL_I4    = 4'd3;
  localparam logic [SEL_WIDTH-1:0] SEL_I5    = 4'd4;
  localparam logic [SEL_WIDTH-1:0] SEL_I6    = 4'd5;
  localparam logic [SEL_WIDTH-1:0] SEL_I7    = 4'd6;
  localparam logic [SEL_WIDTH-1:0] SEL_MUL2  = 4'd7;
  localparam logic [SEL_WIDTH-1:0] SEL_ALU4  = 4'd8;
  localparam logic [SEL_WIDTH-1:0] SEL_MUL6  = 4'd9;
  localparam logic [SEL_WIDTH-1:0] SEL_ALU8  = 4'd10;
  localparam logic [SEL_WIDTH-1:0] SEL_MUL10 = 4'd11;
  localparam logic [SEL_WIDTH-1:0] SEL_ALU12 = 4'd12;
  localparam logic [SEL_WIDTH-1:0] SEL_IDLE  = 4'd15;

  localparam logic ALU_ADD  = 1'b0;
  localparam logic ALU_SUB  = 1'b1;
  localparam logic MUL_MULT = 1'b0;
  localparam logic MUL_DIV  = 1'b1;

  // Multiply steps are the only ones that stretch over MUL_LAT cycles.
  function automatic logic is_mul_state(input state_e s);
    return (s == M2) || (s == M6) || (s == M10);
  endfunction

endpackage

// File: rtl/datapath_controller_wait_counter.sv
// Wait counter for the multi-cycle multiply steps: counts up from 0 while
// clr_i is low and flags the last cycle of a MUL_LAT-long step.
module ctrl_wait_counter #(
  parameter int MUL_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic term_o
);

  localparam int CNT_W = $clog2(MUL_LAT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == CNT_W'(MUL_LAT - 1));

endmodule

// File: rtl/datapath_controller.sv
// Moore controller stepping the six-operation schedule
// result = ((((i1*i2)+i3)*i4)-i5)*i6+i7 on a single-ALU/single-MUL datapath.
module datapath_controller
  import datapath_ctrl_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  output logic             busy,
  output logic [SEL_W-1:0] alu1_sel1,
  output logic [SEL_W-1:0] alu1_sel2,
  output logic             alu1_op,
  output logic [SEL_W-1:0] mul1_sel1,
  output logic [SEL_W-1:0] mul1_sel2,
  output logic             mul1_op,
  output logic             reg_mul2_en,
  output logic             reg_alu4_en,
  output logic             reg_mul6_en,
  output logic             reg_alu8_en,
  output logic             reg_mul10_en,
  output logic             reg_alu12_en,
  output logic             result_en,
  output logic             done_next,
  output state_e           dbg_state_o
);

  // Handshake: a computation is accepted on any rising edge where ready and
  // start are both high; start at any other time is dropped, never queued.

  state_e state_q;
  state_e state_d;
  logic   mul_term;
  logic   cnt_clr;

  function automatic logic [SEL_W-1:0] sel(input logic [SEL_WIDTH-1:0] code);
    return SEL_W'(code);
  endfunction

  // Counter idles at 0 outside multiply steps, so every M step starts at 0.
  assign cnt_clr = !is_mul_state(state_q) || mul_term;

  ctrl_wait_counter #(
    .MUL_LAT (MUL_LAT)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .term_o (mul_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = M2;
      M2:      if (mul_term) state_d = A4;
      A4:      state_d = M6;
      M6:      if (mul_term) state_d = A8;
      A8:      state_d = M10;
      M10:     if (mul_term) state_d = A12;
      A12:     state_d = RES;
      RES:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready        = 1'b0;
    busy         = 1'b1;
    alu1_sel1    = sel(SEL_IDLE);
    alu1_sel2    = sel(SEL_IDLE);
    alu1_op      = ALU_ADD;
    mul1_sel1    = sel(SEL_IDLE);
    mul1_sel2    = sel(SEL_IDLE);
    mul1_op      = MUL_MULT;
    reg_mul2_en  = 1'b0;
    reg_alu4_en  = 1'b0;
    reg_mul6_en  = 1'b0;
    reg_alu8_en  = 1'b0;
    reg_mul10_en = 1'b0;
    reg_alu12_en = 1'b0;
    result_en    = 1'b0;
    done_next    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      M2: begin
        mul1_sel1   = sel(SEL_I1);
        mul1_sel2   = sel(SEL_I2);
        reg_mul2_en = mul_term;
      end
      A4: begin
        alu1_sel1   = sel(SEL_MUL2);
        alu1_sel2   = sel(SEL_I3);
        alu1_op     = ALU_ADD;
        reg_alu4_en = 1'b1;
      end
      M6: begin
        mul1_sel1   = sel(SEL_ALU4);
        mul1_sel2   = sel(SEL_I4);
        reg_mul6_en = mul_term;
      end
      A8: begin
        alu1_sel1   = sel(SEL_MUL6);
        alu1_sel2   = sel(SEL_I5);
        alu1_op     = ALU_SUB;
        reg_alu8_en = 1'b1;
      end
      M10: begin
        mul1_sel1    = sel(SEL_ALU8);
        mul1_sel2    = sel(SEL_I6);
        reg_mul10_en = mul_term;
      end
      A12: begin
        alu1_sel1    = sel(SEL_MUL10);
        alu1_sel2    = sel(SEL_I7);
        alu1_op      = ALU_ADD;
        reg_alu12_en = 1'b1;
      end
      RES: begin
        result_en = 1'b1;
        done_next = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_datapath_controller.sv
// Bench for datapath_controller at MUL_LAT=1 and MUL_LAT=3, each driving a
// behavioural datapath; outputs are checked every cycle against a schedule model.
module tb_datapath_controller;
  import datapath_ctrl_pkg::*;

  typedef struct packed {
    logic [6:0][31:0] in;
    logic [31:0]      exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       start_v;
  logic [6:0][31:0] in_v;

  logic [27:0] obs [2];
  state_e      dbg [2];
  logic [31:0] dp_r [2][6];
  logic [31:0] dp_res [2];
  logic        dp_done [2];

  int checks;
  int failures;
  int pos [2];
  int done_cnt [2];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  vec_t tbl [4];
  logic [31:0] exp_int [6];

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int L = (g == 0) ? 1 : 3;
      logic       ready, busy, alu_op, mul_op, res_en, dn;
      logic [3:0] as1, as2, ms1, ms2;
      logic [5:0] en;
      state_e     st;
      datapath_controller #(.SEL_W(4), .MUL_LAT(L)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start_v[g]),
        .ready        (ready),
        .busy         (busy),
        .alu1_sel1    (as1),
        .alu1_sel2    (as2),
        .alu1_op      (alu_op),
        .mul1_sel1    (ms1),
        .mul1_sel2    (ms2),
        .mul1_op      (mul_op),
        .reg_mul2_en  (en[5]),
        .reg_alu4_en  (en[4]),
        .reg_mul6_en  (en[3]),
        .reg_alu8_en  (en[2]),
        .reg_mul10_en (en[1]),
        .reg_alu12_en (en[0]),
        .result_en    (res_en),
        .done_next    (dn),
        .dbg_state_o  (st)
      );
      assign obs[g] = {as1, as2, alu_op, ms1, ms2, mul_op, en, res_en, dn, ready, busy};
      assign dbg[g] = st;
    end
  endgenerate

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  // Behavioural datapath: operand muxes, one MUL, one ALU, six step registers.
  function automatic logic [31:0] operand(input int g, input logic [3:0] s);
    if (s < 4'd7) return in_v[int'(s)];
    else if (s < 4'd13) return dp_r[g][int'(s) - 7];
    else return 32'd0;
  endfunction

  function automatic logic [31:0] mul_res(input int g);
    return operand(g, obs[g][18:15]) * operand(g, obs[g][14:11]);
  endfunction

  function automatic logic [31:0] alu_res(input int g);
    logic [31:0] a, b;
    a = operand(g, obs[g][27:24]);
    b = operand(g, obs[g][23:20]);
    return obs[g][19] ? (a - b) : (a + b);
  endfunction

  always_ff @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 6; k++) begin
        if (obs[g][9-k]) dp_r[g][k] <= ((k % 2) == 0) ? mul_res(g) : alu_res(g);
      end
      if (rst) begin
        dp_done[g] <= 1'b0;
        dp_res[g]  <= 32'd0;
      end else begin
        dp_done[g] <= obs[g][2];
        if (obs[g][3]) dp_res[g] <= dp_r[g][5];
      end
    end
  end

  function automatic logic [31:0] ref_res(input logic [6:0][31:0] v);
    return ((((v[0] * v[1]) + v[2]) * v[3]) - v[4]) * v[5] + v[6];
  endfunction

  // Expected outputs at position pos of a run (0 = idle, 1.. = cycles since accept).
  function automatic logic [27:0] exp_vec(input int pos_i, input int l);
    logic [3:0] as1 = 4'd15, as2 = 4'd15, ms1 = 4'd15, ms2 = 4'd15;
    logic       aop = 1'b0, re = 1'b0, dn = 1'b0, rdy = 1'b0, bsy = 1'b1;
    logic [5:0] en = 6'd0;
    int p;
    if (pos_i == 0) begin
      rdy = 1'b1;
      bsy = 1'b0;
    end else begin
      p = pos_i - 1;
      if (p < l) begin
        ms1 = 4'd0; ms2 = 4'd1; if (p == l - 1) en = 6'b100000;
      end else if (p == l) begin
        as1 = 4'd7; as2 = 4'd2; en = 6'b010000;
      end else if (p < 2 * l + 1) begin
        ms1 = 4'd8; ms2 = 4'd3; if (p == 2 * l) en = 6'b001000;
      end else if (p == 2 * l + 1) begin
        as1 = 4'd9; as2 = 4'd4; aop = 1'b1; en = 6'b000100;
      end else if (p < 3 * l + 2) begin
        ms1 = 4'd10; ms2 = 4'd5; if (p == 3 * l + 1) en = 6'b000010;
      end else if (p == 3 * l + 2) begin
        as1 = 4'd11; as2 = 4'd6; en = 6'b000001;
      end else begin
        re = 1'b1; dn = 1'b1;
      end
    end
    return {as1, as2, aop, ms1, ms2, 1'b0, en, re, dn, rdy, bsy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the models with the inputs sampled at the last edge, then compare.
  task automatic cycle();
    int l, prev;
    logic [31:0] e;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      l    = lat(g);
      prev = pos[g];
      if (rst) pos[g] = 0;
      else if (prev == 0) pos[g] = start_v[g] ? 1 : 0;
      else if (prev == 3 * l + 4) pos[g] = 0;
      else pos[g] = prev + 1;
      if (rst) begin
        if (g == 0) exp_q0.delete(); else exp_q1.delete();
      end else if (prev == 0 && start_v[g]) begin
        if (g == 0) exp_q0.push_back(ref_res(in_v)); else exp_q1.push_back(ref_res(in_v));
      end
      check($sformatf("outputs_lat%0d_pos%0d", l, pos[g]), {4'd0, obs[g]}, {4'd0, exp_vec(pos[g], l)});
      check($sformatf("done_lat%0d", l), {31'd0, dp_done[g]}, {31'd0, (!rst && prev == 3 * l + 4)});
      if (pos[g] == 0) check($sformatf("idle_state_lat%0d", l), {29'd0, dbg[g]}, {29'd0, IDLE});
      if (dp_done[g]) begin
        done_cnt[g]++;
        if ((g == 0 && exp_q0.size() == 0) || (g == 1 && exp_q1.size() == 0)) begin
          checks++;
          failures++;
          $display("FAIL result_lat%0d unexpected done with no pending run", l);
        end else begin
          e = (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check($sformatf("result_lat%0d", l), dp_res[g], e);
        end
      end
    end
  endtask

  task automatic run_one(input int g, input logic [6:0][31:0] v);
    int n0, t;
    n0 = done_cnt[g];
    in_v = v;
    start_v[g] = 1'b1;
    cycle();
    start_v[g] = 1'b0;
    t = 0;
    while (done_cnt[g] == n0 && t < 60) begin
      cycle();
      t++;
    end
    if (done_cnt[g] == n0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout_lat%0d actual=no_done required=done within 60 cycles", lat(g));
    end
  endtask

  initial begin
    int n0, p;
    logic [6:0][31:0] rv;
    checks   = 0;
    failures = 0;
    pos      = '{0, 0};
    done_cnt = '{0, 0};
    rst      = 1'b1;
    start_v  = 2'b00;
    in_v     = '0;

    tbl[0].in = {32'd1, 32'd3, 32'd6, 32'd2, 32'd5, 32'd4, 32'd3};
    tbl[0].exp = 32'd85;
    tbl[1].in = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd65536, 32'd65536};
    tbl[1].exp = 32'd0;
    tbl[2].in = {32'd0, 32'd1, 32'd2, 32'd1, 32'd0, 32'd1, 32'd1};
    tbl[2].exp = 32'hFFFF_FFFF;
    tbl[3].in = {32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7};
    tbl[3].exp = 32'd2702;
    exp_int = '{32'd12, 32'd17, 32'd34, 32'd28, 32'd84, 32'd85};

    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // Table vectors on both latencies, including the 32-bit wrap cases.
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) begin
        run_one(g, tbl[i].in);
        check($sformatf("tbl%0d_result_lat%0d", i, lat(g)), dp_res[g], tbl[i].exp);
        if (i == 0) begin
          for (int k = 0; k < 6; k++)
            check($sformatf("intermediate%0d_lat%0d", k, lat(g)), dp_r[g][k], exp_int[k]);
        end
      end
    end

    // Randomized operands, alternating full-range and small values.
    for (int g = 0; g < 2; g++) begin
      for (int r = 0; r < 8; r++) begin
        for (int k = 0; k < 7; k++)
          rv[k] = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 20));
        run_one(g, rv);
      end
    end

    // start re-pulsed during A4 must be ignored.
    n0 = done_cnt[0];
    in_v = tbl[0].in;
    start_v[0] = 1'b1;
    cycle();
    start_v[0] = 1'b0;
    cycle();
    check("a4_enable_seen", {31'd0, obs[0][8]}, 32'd1);
    start_v[0] = 1'b1;
    cycle();
    start_v[0] = 1'b0;
    repeat (12) cycle();
    check("repulse_done_count", done_cnt[0] - n0, 32'd1);
    check("repulse_ready", {31'd0, obs[0][1]}, 32'd1);

    // Reset in the middle of the M6 wait count.
    in_v = tbl[2].in;
    start_v[1] = 1'b1;
    cycle();
    start_v[1] = 1'b0;
    for (int t = 0; t < 10 && pos[1] != 6; t++) cycle();
    check("rst_mid_m6_reached", {31'd0, obs[1][4 + 3 - 3 + 3 - 3 + 3 - 3 + 3 - 3 + 3]}, 32'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_enables", {26'd0, obs[1][9:4]}, 32'd0);
    check("rst_busy", {31'd0, obs[1][0]}, 32'd0);
    check("rst_ready", {31'd0, obs[1][1]}, 32'd1);
    run_one(1, tbl[3].in);
    check("post_rst_result", dp_res[1], tbl[3].exp);

    // start held high: three back-to-back runs separated by one IDLE cycle.
    for (int g = 0; g < 2; g++) begin
      p = 3 * lat(g) + 5;
      n0 = done_cnt[g];
      in_v = tbl[0].in;
      start_v[g] = 1'b1;
      repeat (2 * p + 1) cycle();
      start_v[g] = 1'b0;
      repeat (p + 5) cycle();
      check($sformatf("held_done_count_lat%0d", lat(g)), done_cnt[g] - n0, 32'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
